risc_ctrl_fsm: RTL and testbench
================================

// Module: risc_ctrl_fsm
// PURPOSE
// - Instruction-sequencing controller of the 8-bit RISC core; sits directly downstream of the instruction register.
// - Consumes opc_iraddr (opcode = opc_iraddr[15:13]) and the accumulator zero flag.
// - Runs an 8-state per-instruction sequence; emits the PC, ACC, IR, memory and bus-enable strobes.
// - Clocked by clk1 from the clock generator. ena is the fetch-derived run enable from the machine-control stage.
// PARAMETERS
// - IR_W   16  instruction register width; opcode = top OPC_W bits
// - OPC_W   3  opcode width (8 opcodes, encodings fixed below)
// - CNT_W  16  retired-instruction counter width
// PORTS
// - clk1         in   1      single clock, rising edge
// - rst          in   1      synchronous, active-high reset
// - ena          in   1      run enable; 0 = synchronously park in S0
// - zero         in   1      accumulator==0 flag, sampled in S4/S6
// - opc_iraddr   in   IR_W   IR contents; opcode = opc_iraddr[IR_W-1 -: OPC_W]
// - load_ir      out  1      IR byte load strobe
// - rd           out  1      memory read strobe
// - wr           out  1      memory write strobe
// - inc_pc       out  1      PC increment strobe (+1 byte)
// - load_pc      out  1      PC load from IR address field
// - load_acc     out  1      accumulator load strobe
// - datactl_ena  out  1      drive ACC onto data bus
// - halt         out  1      core halted (sticky)
// - state        out  3      current sequence state S0..S7
// - instr_cnt    out  CNT_W  retired-instruction count, wraps
// BEHAVIOUR
// - Opcodes: HLT=000 SKZ=001 ADD=010 AND=011 XOR=100 LDA=101 STO=110 JMP=111.
// - State register 3 bits. Normal advance: S0->S1->...->S7->S0, one state per clk1 edge.
// - Strobes are Moore-decoded from state, opcode and zero; no added latency.
// - All strobes are 0 in any state/opcode combination not listed below.
// - Reset (rst=1 at edge): state=S0, halt=0, instr_cnt=0. All strobes 0 while rst is high.
// - Reset has priority over ena and the halted condition; rst mid-instruction aborts it and resumes at S0.
// - ena=0 at edge: state<=S0; strobes forced 0 while ena=0. halt and instr_cnt hold.
// - ena rising: sequence starts at S0 on the following cycle.
// - Per-state strobes:
//   - S0: rd=1, load_ir=1 (high IR byte).
//   - S1: inc_pc=1.
//   - S2: rd=1, load_ir=1 (low IR byte).
//   - S3: inc_pc=1. If opcode=HLT: halt<=1 at the S3 edge; state then freezes at S3 with all strobes 0.
//   - S4: ADD/AND/XOR/LDA: rd=1. STO: datactl_ena=1. JMP: load_pc=1. SKZ with zero=1: inc_pc=1.
//   - S5: ADD/AND/XOR/LDA: rd=1, load_acc=1. STO: datactl_ena=1, wr=1. JMP: load_pc=1.
//   - S6: STO: datactl_ena=1. SKZ with zero=1: inc_pc=1 (second byte of skipped instruction).
//   - S7: no strobes. instr_cnt<=instr_cnt+1 at the S7->S0 edge (mod 2^CNT_W).
// - SKZ samples zero independently in S4 and S6; the ACC is not modified by SKZ, so both samples agree.
// - Halted: state stays S3, halt=1, instr_cnt frozen; only rst exits. ena has no effect while halted.
// - Invariants:
//   - wr only in S5, and only for STO.
//   - wr=1 implies datactl_ena=1.
//   - rd and wr never high together.
//   - load_pc and inc_pc never high together.
// TESTING
// - rst=1 for 2 cycles, then ena=1, opcode ADD: strobes S0..S7 = {rd+load_ir, inc_pc, rd+load_ir, inc_pc, rd, rd+load_acc, -, -}; instr_cnt 0->1 after 8 cycles.
// - Opcode STO: datactl_ena high in S4-S6; wr high only in S5; rd never high in S4-S7.
// - SKZ with zero=1: inc_pc high in S1, S3, S4, S6 (4 pulses). Same with zero=0: inc_pc in S1, S3 only.
// - HLT: halt=1 from the cycle after S3 and state stuck at 3 for 20 cycles; rst=1 then clears halt and state=0.
// - ena dropped in S5 of LDA: next cycle state=0 and all strobes 0. ena back high: a full sequence restarts from S0.
// - Preload instr_cnt near wrap (CNT_W=4, run 16 JMPs): count wraps 15->0. JMP asserts load_pc in S4 and S5 only.

Source files
------------

// File: rtl/risc_ctrl_fsm.sv
// risc_ctrl_fsm: instruction-sequencing controller of the 8-bit RISC core.
// Walks an 8-state per-instruction sequence (S0..S7) and decodes the PC, ACC,
// IR, memory and bus-enable strobes from state, opcode and the zero flag.
//
// Ports:
//   clk1         in   1      clock, rising edge
//   rst          in   1      synchronous active-high reset
//   ena          in   1      run enable; low parks the sequence in S0
//   zero         in   1      accumulator==0 flag (used by SKZ in S4/S6)
//   opc_iraddr   in   IR_W   IR contents; opcode in the top OPC_W bits
//   load_ir      out  1      IR byte load strobe
//   rd           out  1      memory read strobe
//   wr           out  1      memory write strobe
//   inc_pc       out  1      PC increment strobe
//   load_pc      out  1      PC load from IR address field
//   load_acc     out  1      accumulator load strobe
//   datactl_ena  out  1      drive ACC onto the data bus
//   halt         out  1      sticky halted flag
//   state        out  3      current sequence state
//   instr_cnt    out  CNT_W  retired-instruction counter (wraps)
module risc_ctrl_fsm #(
    parameter int unsigned IR_W  = 16,
    parameter int unsigned OPC_W = 3,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk1,
    input  logic             rst,
    input  logic             ena,
    input  logic             zero,
    input  logic [IR_W-1:0]  opc_iraddr,
    output logic             load_ir,
    output logic             rd,
    output logic             wr,
    output logic             inc_pc,
    output logic             load_pc,
    output logic             load_acc,
    output logic             datactl_ena,
    output logic             halt,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [2:0] {
        S0 = 3'd0, S1 = 3'd1, S2 = 3'd2, S3 = 3'd3,
        S4 = 3'd4, S5 = 3'd5, S6 = 3'd6, S7 = 3'd7
    } state_t;

    localparam logic [OPC_W-1:0] OP_HLT = OPC_W'(0);
    localparam logic [OPC_W-1:0] OP_SKZ = OPC_W'(1);
    localparam logic [OPC_W-1:0] OP_ADD = OPC_W'(2);
    localparam logic [OPC_W-1:0] OP_AND = OPC_W'(3);
    localparam logic [OPC_W-1:0] OP_XOR = OPC_W'(4);
    localparam logic [OPC_W-1:0] OP_LDA = OPC_W'(5);
    localparam logic [OPC_W-1:0] OP_STO = OPC_W'(6);
    localparam logic [OPC_W-1:0] OP_JMP = OPC_W'(7);

    state_t             state_q;
    state_t             state_d;
    logic               halt_d;
    logic [CNT_W-1:0]   cnt_d;
    logic [OPC_W-1:0]   opcode;
    logic               alu_op;
    logic               run;
    logic               unused_addr;

    assign opcode      = opc_iraddr[IR_W-1 -: OPC_W];
    // Address field is consumed by the datapath, not by the sequencer.
    assign unused_addr = ^opc_iraddr[IR_W-OPC_W-1:0];
    assign alu_op      = (opcode == OP_ADD) || (opcode == OP_AND) ||
                         (opcode == OP_XOR) || (opcode == OP_LDA);
    // Strobes only fire while actively sequencing.
    assign run         = !rst && ena && !halt;
    assign state       = state_q;

    // State, halt flag and retired-instruction counter.
    always_ff @(posedge clk1) begin
        if (rst) begin
            state_q   <= S0;
            halt      <= 1'b0;
            instr_cnt <= '0;
        end else begin
            state_q   <= state_d;
            halt      <= halt_d;
            instr_cnt <= cnt_d;
        end
    end

    // Next-state and Moore strobe decode.
    always_comb begin
        state_d     = state_q;
        halt_d      = halt;
        cnt_d       = instr_cnt;
        load_ir     = 1'b0;
        rd          = 1'b0;
        wr          = 1'b0;
        inc_pc      = 1'b0;
        load_pc     = 1'b0;
        load_acc    = 1'b0;
        datactl_ena = 1'b0;

        // Halted freezes everything; only reset (in the register) exits.
        if (!halt) begin
            if (!ena) begin
                state_d = S0;
            end else if (state_q == S3 && opcode == OP_HLT) begin
                halt_d = 1'b1;
            end else begin
                state_d = state_t'(3'(state_q + 3'd1));
                if (state_q == S7) begin
                    cnt_d = instr_cnt + CNT_W'(1);
                end
            end
        end

        if (run) begin
            case (state_q)
                S0, S2: begin
                    rd      = 1'b1;
                    load_ir = 1'b1;
                end
                S1, S3: inc_pc = 1'b1;
                S4: begin
                    if (alu_op) begin
                        rd = 1'b1;
                    end else if (opcode == OP_STO) begin
                        datactl_ena = 1'b1;
                    end else if (opcode == OP_JMP) begin
                        load_pc = 1'b1;
                    end else if (opcode == OP_SKZ && zero) begin
                        inc_pc = 1'b1;
                    end
                end
                S5: begin
                    if (alu_op) begin
                        rd       = 1'b1;
                        load_acc = 1'b1;
                    end else if (opcode == OP_STO) begin
                        datactl_ena = 1'b1;
                        wr          = 1'b1;
                    end else if (opcode == OP_JMP) begin
                        load_pc = 1'b1;
                    end
                end
                S6: begin
                    if (opcode == OP_STO) begin
                        datactl_ena = 1'b1;
                    end else if (opcode == OP_SKZ && zero) begin
                        inc_pc = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_risc_ctrl_fsm.sv
// Self-checking bench for risc_ctrl_fsm: directed scenarios plus randomized
// cycles, compared against a phase/halt/count reference model.
module tb_risc_ctrl_fsm;

    localparam int unsigned IR_W  = 16;
    localparam int unsigned OPC_W = 3;
    localparam int unsigned CNT_W = 4;

    localparam int HLT = 0, SKZ = 1, ADD = 2, AND_ = 3, XOR_ = 4, LDA = 5, STO = 6, JMP = 7;

    logic             clk1 = 1'b0;
    logic             rst, ena, zero;
    logic [IR_W-1:0]  opc_iraddr;
    logic             load_ir, rd, wr, inc_pc, load_pc, load_acc, datactl_ena, halt;
    logic [2:0]       state;
    logic [CNT_W-1:0] instr_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: position within instruction, halted flag, retired count.
    int m_ph   = 0;
    bit m_halt = 1'b0;
    int m_cnt  = 0;
    int cur_op = 0;

    always #5 clk1 = ~clk1;

    risc_ctrl_fsm #(.IR_W(IR_W), .OPC_W(OPC_W), .CNT_W(CNT_W)) dut (
        .clk1(clk1), .rst(rst), .ena(ena), .zero(zero), .opc_iraddr(opc_iraddr),
        .load_ir(load_ir), .rd(rd), .wr(wr), .inc_pc(inc_pc), .load_pc(load_pc),
        .load_acc(load_acc), .datactl_ena(datactl_ena), .halt(halt),
        .state(state), .instr_cnt(instr_cnt)
    );

    // Expected strobes {load_ir, rd, wr, inc_pc, load_pc, load_acc, datactl_ena}
    function automatic logic [6:0] exp_strobes(int ph, int op, bit z);
        bit alu = (op == ADD) || (op == AND_) || (op == XOR_) || (op == LDA);
        case (ph)
            0, 2: return 7'b1100000;
            1, 3: return 7'b0001000;
            4: begin
                if (alu)                  return 7'b0100000;
                if (op == STO)            return 7'b0000001;
                if (op == JMP)            return 7'b0000100;
                if (op == SKZ && z)       return 7'b0001000;
                return 7'b0;
            end
            5: begin
                if (alu)                  return 7'b0100010;
                if (op == STO)            return 7'b0010001;
                if (op == JMP)            return 7'b0000100;
                return 7'b0;
            end
            6: begin
                if (op == STO)            return 7'b0000001;
                if (op == SKZ && z)       return 7'b0001000;
                return 7'b0;
            end
            default: return 7'b0;
        endcase
    endfunction

    task automatic check();
        logic [6:0] obs, exp;
        obs = {load_ir, rd, wr, inc_pc, load_pc, load_acc, datactl_ena};
        exp = (rst || !ena || m_halt) ? 7'b0 : exp_strobes(m_ph, cur_op, zero);
        n_cmp++;
        assert (state === 3'(m_ph)) else begin
            n_bad++;
            $error("FAIL state: observed %0d expected %0d", state, m_ph);
        end
        n_cmp++;
        assert (halt === m_halt) else begin
            n_bad++;
            $error("FAIL halt: observed %0b expected %0b", halt, m_halt);
        end
        n_cmp++;
        assert (instr_cnt === CNT_W'(m_cnt)) else begin
            n_bad++;
            $error("FAIL instr_cnt: observed %0d expected %0d", instr_cnt, m_cnt);
        end
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL strobes ph%0d op%0d: observed %b expected %b", m_ph, cur_op, obs, exp);
        end
    endtask

    // Model update for one rising edge using the inputs held over the cycle.
    task automatic model_edge();
        if (rst) begin
            m_ph = 0; m_halt = 1'b0; m_cnt = 0;
        end else if (m_halt) begin
            // frozen until reset
        end else if (!ena) begin
            m_ph = 0;
        end else if (m_ph == 3 && cur_op == HLT) begin
            m_halt = 1'b1;
        end else begin
            if (m_ph == 7) m_cnt = (m_cnt + 1) % (1 << CNT_W);
            m_ph = (m_ph + 1) % 8;
        end
    endtask

    // Check mid-cycle, then advance across one rising edge.
    task automatic tick();
        @(negedge clk1);
        check();
        @(posedge clk1);
        model_edge();
        #1;
    endtask

    task automatic set_op(int op);
        cur_op     = op;
        opc_iraddr = {OPC_W'(op), (IR_W-OPC_W)'($urandom)};
    endtask

    task automatic run_instr(int op, bit z);
        set_op(op);
        zero = z;
        repeat (8) tick();
    endtask

    initial begin
        rst = 1'b1; ena = 1'b0; zero = 1'b0;
        set_op(ADD);
        @(posedge clk1); #1;
        // Reset held for two checked cycles.
        repeat (2) tick();
        rst = 1'b0; ena = 1'b1;

        run_instr(ADD, 1'($urandom));
        run_instr(STO, 1'($urandom));
        run_instr(SKZ, 1'b1);
        run_instr(SKZ, 1'b0);

        // LDA with ena dropped while in S5, then a full restart.
        set_op(LDA);
        repeat (5) tick();
        ena = 1'b0;
        repeat (2) tick();
        ena = 1'b1;
        run_instr(LDA, 1'b0);

        // Sixteen JMPs carry the 4-bit count through 15 -> 0.
        repeat (16) run_instr(JMP, 1'($urandom));

        // Randomized cycles: no HLT, occasional ena drop and reset.
        for (int i = 0; i < 400; i++) begin
            if (m_ph == 0) set_op($urandom_range(1, 7));
            zero = 1'($urandom);
            ena  = ($urandom_range(0, 15) != 0);
            rst  = ($urandom_range(0, 63) == 0);
            tick();
        end
        rst = 1'b0; ena = 1'b1;
        while (m_ph != 0) tick();

        // HLT: freeze at S3 regardless of ena, then reset recovers.
        set_op(HLT);
        zero = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < 20; i++) begin
            ena = 1'($urandom);
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0; ena = 1'b1;
        set_op(ADD);
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
